// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared types and constants for the universal-shift-register serial receiver.
//   DIR_*      : word bit-order encodings carried on the 'dir' input
//   state_e    : receiver FSM states (IDLE = no partial word, SHIFT = partial)
//   sr_op_e    : operation applied to the receive shift register in a cycle
// -----------------------------------------------------------------------------
package usr_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;  // bit enters at [0], moves up
    localparam logic DIR_LSB_FIRST = 1'b1;  // bit enters at [WIDTH-1], moves down

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SR_HOLD  = 2'd0,
        SR_UP    = 2'd1,
        SR_DOWN  = 2'd2,
        SR_CLEAR = 2'd3
    } sr_op_e;

endpackage

// File: rtl/rx_shift_core.sv
// -----------------------------------------------------------------------------
// rx_shift_core
// WIDTH-bit receive shift register with a per-bit next-state mux.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset (clears the register)
//   i_op       in   hold / shift-up / shift-down / clear
//   i_sin      in   serial bit entering the register on a shift
//   o_sr_next  out  value the register takes at the next edge; the top uses
//                   it to capture a completed word including its last bit
// -----------------------------------------------------------------------------
module rx_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  sr_op_e           i_op,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_sr_next
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_up_src;
        logic w_dn_src;
        logic w_nxt;

        // End bits take the serial input; inner bits take their neighbour.
        if (i == 0) begin : g_up_end
            assign w_up_src = i_sin;
        end else begin : g_up_mid
            assign w_up_src = r_sr[i-1];
        end

        if (i == WIDTH - 1) begin : g_dn_end
            assign w_dn_src = i_sin;
        end else begin : g_dn_mid
            assign w_dn_src = r_sr[i+1];
        end

        always_comb begin
            // NOTE: default assigned first so no path leaves w_nxt unassigned (no latch).
            w_nxt = r_sr[i];
            case (i_op)
                SR_UP:    w_nxt = w_up_src;
                SR_DOWN:  w_nxt = w_dn_src;
                SR_CLEAR: w_nxt = 1'b0;
                default:  w_nxt = r_sr[i];
            endcase
        end

        assign w_sr_next[i] = w_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

    assign o_sr_next = w_sr_next;

endmodule

// File: rtl/usr_deserializer.sv
// -----------------------------------------------------------------------------
// usr_deserializer
// Serial-to-parallel receiver: one qualified bit per strobe, bit order chosen
// per word, completed words handed off through a one-entry valid/ready holding
// register; a word completing while the holder is full is dropped and flagged.
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   sin         in   serial data bit
//   sin_valid   in   qualifies sin
//   dir         in   0 = MSB-first, 1 = LSB-first; sampled on a word's first bit
//   abort       in   discard the partial word (and any bit this cycle)
//   ovr_clr     in   clear sticky overrun (a simultaneous overrun wins)
//   dout        out  held word
//   dout_valid  out  holding register full
//   dout_ready  in   consumer accepts dout when dout_valid & dout_ready
//   busy        out  partial word in progress
//   overrun     out  sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module usr_deserializer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             abort,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_next;
    logic             r_dir_q;
    logic             w_dir_q_next;
    sr_op_e           w_sr_op;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic             w_accept;

    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;

    rx_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_op      (w_sr_op),
        .i_sin     (sin),
        .o_sr_next (w_sr_next)
    );

    // State register.
    // NOTE: the async reset only touches these small control/data registers; no memories here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_dir_q   <= DIR_MSB_FIRST;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_dir_q   <= w_dir_q_next;
        end
    end

    // Next-state, counter and shift-register control.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_dir_q_next   = r_dir_q;
        w_sr_op        = SR_HOLD;
        w_complete     = 1'b0;

        if (abort) begin
            // Abort outranks a same-cycle bit: that bit is discarded too.
            w_state_next   = ST_IDLE;
            w_bit_cnt_next = '0;
            w_sr_op        = SR_CLEAR;
        end else if (sin_valid) begin
            if (r_state == ST_IDLE) begin
                // First bit: bit order is frozen here for the whole word.
                w_dir_q_next   = dir;
                w_bit_cnt_next = CNT_W'(1);
                w_state_next   = ST_SHIFT;
                w_sr_op        = (dir == DIR_LSB_FIRST) ? SR_DOWN : SR_UP;
            end else begin
                w_sr_op = (r_dir_q == DIR_LSB_FIRST) ? SR_DOWN : SR_UP;
                if (r_bit_cnt == LAST_CNT) begin
                    // Explicit wrap: the counter never stores WIDTH.
                    w_complete     = 1'b1;
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // A completed word may load into a holder that is being emptied this cycle.
    assign w_accept = r_dout_valid & dout_ready;
    assign w_load   = w_complete & (~r_dout_valid | dout_ready);
    assign w_drop   = w_complete & ~w_load;

    // Holding register and sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_dout       <= w_sr_next;
                r_dout_valid <= 1'b1;
            end else if (w_accept) begin
                r_dout_valid <= 1'b0;
            end

            // Set has priority over clear so a same-cycle drop is never lost.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state == ST_SHIFT);

endmodule
